// File: rtl/csa_pkg.sv
// csa_pkg: shared defaults and operation encoding for the carry-select adder staging.
// Imported by csa_pipe_reg and csa_pipe_stage.
package csa_pkg;

  localparam int unsigned CSA_N     = 32;
  localparam int unsigned CSA_CNT_W = 16;

  typedef logic csa_op_t;

  localparam csa_op_t CSA_OP_ADD = 1'b0;
  localparam csa_op_t CSA_OP_SUB = 1'b1;

  // Subtraction is A + ~B + 1, so the carry-in is forced high and s_cin is ignored.
  function automatic logic csa_cond_cin(input csa_op_t op, input logic cin);
    return (op == CSA_OP_SUB) | cin;
  endfunction

  function automatic logic [1:0] csa_unused_guard(input csa_op_t op);
    return {op == CSA_OP_ADD, op == CSA_OP_SUB};
  endfunction

endpackage

// File: rtl/csa_pipe_reg.sv
// csa_pipe_reg: generic one-entry valid/ready register slice of data width W.
// Data loads only on an input handshake; valid drops when the output is taken without a refill.
module csa_pipe_reg
  import csa_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic [W-1:0] data_q;
  logic         load;

  // Ready never looks at in_valid, so upstream sees no combinational loop.
  assign in_ready = ~valid_q | out_ready;
  assign load     = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/csa_pipe_stage.sv
// csa_pipe_stage: operand and result staging around an external combinational N-bit adder.
// Defining CSA_OVF_EN adds the signed-overflow output m_ovf and its register.
module csa_pipe_stage
  import csa_pkg::*;
#(
  parameter int unsigned N     = CSA_N,
  parameter int unsigned CNT_W = CSA_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [N-1:0]     s_a,
  input  logic [N-1:0]     s_b,
  input  logic             s_cin,
  input  logic             s_sub,
  output logic [N-1:0]     add_a,
  output logic [N-1:0]     add_b,
  output logic             add_cin,
  input  logic [N-1:0]     add_sum,
  input  logic             add_cout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [N-1:0]     m_sum,
  output logic             m_cout,
`ifdef CSA_OVF_EN
  output logic             m_ovf,
`endif
  output logic [CNT_W-1:0] done_cnt
);

  localparam int unsigned OpW = 2 * N + 1;
`ifdef CSA_OVF_EN
  localparam int unsigned ResW = N + 2;
`else
  localparam int unsigned ResW = N + 1;
`endif

  logic [N-1:0]     b_cond;
  logic             cin_cond;
  logic [OpW-1:0]   op_in;
  logic [OpW-1:0]   op_out;
  logic             op_v;
  logic             res_in_ready;
  logic [ResW-1:0]  res_in;
  logic [ResW-1:0]  res_out;
  logic             res_hs;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    b_cond   = (s_sub == CSA_OP_SUB) ? ~s_b : s_b;
    cin_cond = csa_cond_cin(s_sub, s_cin);
  end

  assign op_in = {s_a, b_cond, cin_cond};

  // Operand register: its outputs drive the adder directly and change only on accept.
  csa_pipe_reg #(
    .W (OpW)
  ) u_op_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_valid),
    .in_ready  (s_ready),
    .in_data   (op_in),
    .out_valid (op_v),
    .out_ready (res_in_ready),
    .out_data  (op_out)
  );

  assign {add_a, add_b, add_cin} = op_out;

`ifdef CSA_OVF_EN
  logic ovf_calc;
  // add_b is already conditioned, so the same test covers add and sub.
  assign ovf_calc = (add_a[N-1] == add_b[N-1]) & (add_sum[N-1] != add_a[N-1]);
  assign res_in   = {ovf_calc, add_cout, add_sum};
`else
  assign res_in   = {add_cout, add_sum};
`endif

  // Result register: loads on advance = op_v & (~m_valid | m_ready).
  csa_pipe_reg #(
    .W (ResW)
  ) u_res_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (op_v),
    .in_ready  (res_in_ready),
    .in_data   (res_in),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (res_out)
  );

`ifdef CSA_OVF_EN
  assign {m_ovf, m_cout, m_sum} = res_out;
`else
  assign {m_cout, m_sum} = res_out;
`endif

  assign res_hs = m_valid & m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (res_hs) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign done_cnt = cnt_q;

  // A stalled result must not move, and the adder inputs only move on accept.
  property p_res_hold;
    @(posedge clk) disable iff (!rst_n)
      (m_valid && !m_ready) |=> (m_valid && $stable(m_sum) && $stable(m_cout));
  endproperty
  a_res_hold: assert property (p_res_hold);

  property p_op_hold;
    @(posedge clk) disable iff (!rst_n)
      !(s_valid && s_ready) |=> ($stable(add_a) && $stable(add_b) && $stable(add_cin));
  endproperty
  a_op_hold: assert property (p_op_hold);

endmodule

// File: tb/tb_csa_pipe_stage.sv
// tb_csa_pipe_stage: directed checks of csa_pipe_stage with N=32, CNT_W=4 and a behavioural adder.
// m_ovf is checked only when CSA_OVF_EN is defined.
module tb_csa_pipe_stage;

  localparam int unsigned N     = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             s_valid;
  logic             s_ready;
  logic [N-1:0]     s_a;
  logic [N-1:0]     s_b;
  logic             s_cin;
  logic             s_sub;
  logic [N-1:0]     add_a;
  logic [N-1:0]     add_b;
  logic             add_cin;
  logic [N-1:0]     add_sum;
  logic             add_cout;
  logic             m_valid;
  logic             m_ready;
  logic [N-1:0]     m_sum;
  logic             m_cout;
`ifdef CSA_OVF_EN
  logic             m_ovf;
`endif
  logic [CNT_W-1:0] done_cnt;

  int total;
  int bad;
  int exp_cnt;

  // Stand-in for the combinational carry-select adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

  csa_pipe_stage #(
    .N     (N),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_a      (s_a),
    .s_b      (s_b),
    .s_cin    (s_cin),
    .s_sub    (s_sub),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_sum    (m_sum),
    .m_cout   (m_cout),
`ifdef CSA_OVF_EN
    .m_ovf    (m_ovf),
`endif
    .done_cnt (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic cin, input logic sub);
    s_valid = v;
    s_a     = a;
    s_b     = b;
    s_cin   = cin;
    s_sub   = sub;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #12;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b want=0", m_valid); end
    total++; if (add_a !== '0) begin bad++; $display("FAIL rst_add_a got=%h want=0", add_a); end
    total++; if (add_b !== '0) begin bad++; $display("FAIL rst_add_b got=%h want=0", add_b); end
    total++; if (add_cin !== 1'b0) begin bad++; $display("FAIL rst_add_cin got=%b want=0", add_cin); end
    total++; if (m_sum !== '0) begin bad++; $display("FAIL rst_m_sum got=%h want=0", m_sum); end
    total++; if (m_cout !== 1'b0) begin bad++; $display("FAIL rst_m_cout got=%b want=0", m_cout); end
`ifdef CSA_OVF_EN
    total++; if (m_ovf !== 1'b0) begin bad++; $display("FAIL rst_m_ovf got=%b want=0", m_ovf); end
`endif
    total++; if (done_cnt !== '0) begin bad++; $display("FAIL rst_done_cnt got=%0d want=0", done_cnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_s_ready got=%b want=1", s_ready); end
    exp_cnt = 0;
  endtask

  task automatic test_add();
    m_ready = 1'b1;
    drive(1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    total++; if (add_a !== 32'h0000_0001) begin bad++; $display("FAIL add_add_a got=%h want=00000001", add_a); end
    total++; if (add_b !== 32'hFFFF_FFFF) begin bad++; $display("FAIL add_add_b got=%h want=ffffffff", add_b); end
    total++; if (add_cin !== 1'b0) begin bad++; $display("FAIL add_add_cin got=%b want=0", add_cin); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL add_latency1 got=%b want=0", m_valid); end
    tick();
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL add_m_valid got=%b want=1", m_valid); end
    total++; if (m_sum !== 32'h0) begin bad++; $display("FAIL add_m_sum got=%h want=00000000", m_sum); end
    total++; if (m_cout !== 1'b1) begin bad++; $display("FAIL add_m_cout got=%b want=1", m_cout); end
`ifdef CSA_OVF_EN
    total++; if (m_ovf !== 1'b0) begin bad++; $display("FAIL add_m_ovf got=%b want=0", m_ovf); end
`endif
    tick();
    exp_cnt++;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%b want=0", m_valid); end
    total++; if (done_cnt !== 4'd1) begin bad++; $display("FAIL add_done_cnt got=%0d want=1", done_cnt); end
    // carry-in honoured on add: 10 + 20 + 1
    drive(1'b1, 32'd10, 32'd20, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    total++; if (add_cin !== 1'b1) begin bad++; $display("FAIL cin_add_cin got=%b want=1", add_cin); end
    tick();
    total++; if (m_sum !== 32'd31) begin bad++; $display("FAIL cin_m_sum got=%h want=0000001f", m_sum); end
    total++; if (m_cout !== 1'b0) begin bad++; $display("FAIL cin_m_cout got=%b want=0", m_cout); end
    tick();
    exp_cnt++;
  endtask

  task automatic test_sub();
    m_ready = 1'b1;
    // cin=1 must be ignored on subtract
    drive(1'b1, 32'd5, 32'd7, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    total++; if (add_b !== 32'hFFFF_FFF8) begin bad++; $display("FAIL sub_add_b got=%h want=fffffff8", add_b); end
    total++; if (add_cin !== 1'b1) begin bad++; $display("FAIL sub_add_cin got=%b want=1", add_cin); end
    tick();
    total++; if (m_sum !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_m_sum got=%h want=fffffffe", m_sum); end
    total++; if (m_cout !== 1'b0) begin bad++; $display("FAIL sub_m_cout got=%b want=0", m_cout); end
`ifdef CSA_OVF_EN
    total++; if (m_ovf !== 1'b0) begin bad++; $display("FAIL sub_m_ovf got=%b want=0", m_ovf); end
`endif
    tick();
    exp_cnt++;
    total++; if (done_cnt !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL sub_done_cnt got=%0d want=%0d", done_cnt, CNT_W'(exp_cnt)); end
  endtask

  task automatic test_overflow();
    m_ready = 1'b1;
    drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    total++; if (m_sum !== 32'h8000_0000) begin bad++; $display("FAIL ovf1_m_sum got=%h want=80000000", m_sum); end
    total++; if (m_cout !== 1'b0) begin bad++; $display("FAIL ovf1_m_cout got=%b want=0", m_cout); end
`ifdef CSA_OVF_EN
    total++; if (m_ovf !== 1'b1) begin bad++; $display("FAIL ovf1_m_ovf got=%b want=1", m_ovf); end
`endif
    tick();
    exp_cnt++;
    drive(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    total++; if (m_sum !== 32'h7FFF_FFFF) begin bad++; $display("FAIL ovf2_m_sum got=%h want=7fffffff", m_sum); end
    total++; if (m_cout !== 1'b1) begin bad++; $display("FAIL ovf2_m_cout got=%b want=1", m_cout); end
`ifdef CSA_OVF_EN
    total++; if (m_ovf !== 1'b1) begin bad++; $display("FAIL ovf2_m_ovf got=%b want=1", m_ovf); end
`endif
    tick();
    exp_cnt++;
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    drive(1'b1, 32'd100, 32'd1, 1'b0, 1'b0);
    #1;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL bp_s_ready1 got=%b want=1", s_ready); end
    tick();
    drive(1'b1, 32'd200, 32'd2, 1'b0, 1'b0);
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL bp_s_ready2 got=%b want=1", s_ready); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL bp_m_valid1 got=%b want=0", m_valid); end
    tick();
    drive(1'b1, 32'd300, 32'd3, 1'b0, 1'b0);
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL bp_s_ready3 got=%b want=0", s_ready); end
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL bp_m_valid2 got=%b want=1", m_valid); end
    total++; if (m_sum !== 32'd101) begin bad++; $display("FAIL bp_first got=%0d want=101", m_sum); end
    tick();
    total++; if (m_sum !== 32'd101) begin bad++; $display("FAIL bp_hold got=%0d want=101", m_sum); end
    total++; if (add_a !== 32'd200) begin bad++; $display("FAIL bp_opreg got=%0d want=200", add_a); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL bp_s_ready4 got=%b want=0", s_ready); end
    m_ready = 1'b1;
    #1;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", s_ready); end
    tick();
    exp_cnt++;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    total++; if (m_sum !== 32'd202) begin bad++; $display("FAIL bp_second got=%0d want=202", m_sum); end
    total++; if (add_a !== 32'd300) begin bad++; $display("FAIL bp_reload got=%0d want=300", add_a); end
    tick();
    exp_cnt++;
    total++; if (m_sum !== 32'd303) begin bad++; $display("FAIL bp_third got=%0d want=303", m_sum); end
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL bp_third_valid got=%b want=1", m_valid); end
    tick();
    exp_cnt++;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", m_valid); end
    total++; if (done_cnt !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL bp_done_cnt got=%0d want=%0d", done_cnt, CNT_W'(exp_cnt)); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] va [4];
    logic [N-1:0] vb [4];
    logic [N-1:0] vsum [4];
    logic         vcin [4];
    logic         vsub [4];
    logic         vcout [4];
`ifdef CSA_OVF_EN
    logic         vovf [4];
    vovf  = '{1'b0, 1'b1, 1'b0, 1'b0};
`endif
    va    = '{32'h0000_0010, 32'h8000_0000, 32'h0000_0003, 32'hFFFF_FFFF};
    vb    = '{32'h0000_0020, 32'h8000_0000, 32'h0000_0003, 32'h0000_0001};
    vcin  = '{1'b0, 1'b0, 1'b0, 1'b1};
    vsub  = '{1'b0, 1'b0, 1'b1, 1'b0};
    vsum  = '{32'h0000_0030, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001};
    vcout = '{1'b0, 1'b1, 1'b1, 1'b1};
    m_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      if (j < 4) drive(1'b1, va[j], vb[j], vcin[j], vsub[j]);
      else drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL b2b_s_ready[%0d] got=%b want=1", j, s_ready); end
      if (j >= 2) begin
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b want=1", j, m_valid); end
        total++; if (m_sum !== vsum[j-2]) begin bad++; $display("FAIL b2b_sum[%0d] got=%h want=%h", j, m_sum, vsum[j-2]); end
        total++; if (m_cout !== vcout[j-2]) begin bad++; $display("FAIL b2b_cout[%0d] got=%b want=%b", j, m_cout, vcout[j-2]); end
`ifdef CSA_OVF_EN
        total++; if (m_ovf !== vovf[j-2]) begin bad++; $display("FAIL b2b_ovf[%0d] got=%b want=%b", j, m_ovf, vovf[j-2]); end
`endif
      end else begin
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL b2b_fill[%0d] got=%b want=0", j, m_valid); end
      end
      tick();
    end
    exp_cnt += 4;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b want=0", m_valid); end
    total++; if (done_cnt !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL b2b_done_cnt got=%0d want=%0d", done_cnt, CNT_W'(exp_cnt)); end
  endtask

  task automatic test_soak();
    logic         mo_v;
    logic         mr_v;
    logic [N:0]   mo_res;
    logic [N:0]   mr_res;
    logic         adv;
    logic         sr;
    logic         sv;
    logic         mr;
    logic         cin;
    logic         sub;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] bb;
    mo_v   = 1'b0;
    mr_v   = 1'b0;
    mo_res = '0;
    mr_res = '0;
    for (int i = 0; i < 60; i++) begin
      sv  = ($urandom_range(0, 9) < 6);
      mr  = ($urandom_range(0, 9) < 6);
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      m_ready = mr;
      drive(sv, a, b, cin, sub);
      #1;
      adv = mo_v & (~mr_v | mr);
      sr  = ~mo_v | adv;
      total++; if (s_ready !== sr) begin bad++; $display("FAIL soak_s_ready[%0d] got=%b want=%b", i, s_ready, sr); end
      total++; if (m_valid !== mr_v) begin bad++; $display("FAIL soak_m_valid[%0d] got=%b want=%b", i, m_valid, mr_v); end
      if (mr_v) begin
        total++;
        if ({m_cout, m_sum} !== mr_res) begin
          bad++; $display("FAIL soak_result[%0d] got=%h want=%h", i, {m_cout, m_sum}, mr_res);
        end
      end
      if (mr_v && mr) exp_cnt++;
      if (adv) begin
        mr_v   = 1'b1;
        mr_res = mo_res;
      end else if (mr_v && mr) begin
        mr_v = 1'b0;
      end
      if (sv && sr) begin
        bb     = sub ? ~b : b;
        mo_v   = 1'b1;
        mo_res = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, sub | cin};
      end else if (adv) begin
        mo_v = 1'b0;
      end
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    m_ready = 1'b1;
    exp_cnt += int'(mo_v) + int'(mr_v);
    tick();
    tick();
    tick();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL soak_drain got=%b want=0", m_valid); end
    total++; if (done_cnt !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL soak_done_cnt got=%0d want=%0d", done_cnt, CNT_W'(exp_cnt)); end
  endtask

  task automatic test_reset_midflight();
    m_ready = 1'b0;
    drive(1'b1, 32'd11, 32'd22, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'd33, 32'd44, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b want=1", m_valid); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL mid_pre_ready got=%b want=0", s_ready); end
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_m_valid got=%b want=0", m_valid); end
    total++; if (add_a !== '0) begin bad++; $display("FAIL mid_add_a got=%h want=0", add_a); end
    total++; if (add_b !== '0) begin bad++; $display("FAIL mid_add_b got=%h want=0", add_b); end
    total++; if (add_cin !== 1'b0) begin bad++; $display("FAIL mid_add_cin got=%b want=0", add_cin); end
    total++; if (m_sum !== '0) begin bad++; $display("FAIL mid_m_sum got=%h want=0", m_sum); end
    total++; if (m_cout !== 1'b0) begin bad++; $display("FAIL mid_m_cout got=%b want=0", m_cout); end
    total++; if (done_cnt !== '0) begin bad++; $display("FAIL mid_done_cnt got=%0d want=0", done_cnt); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL mid_s_ready got=%b want=1", s_ready); end
    tick();
    tick();
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_stale[%0d] got=%b want=0", k, m_valid); end
    end
  endtask

  task automatic test_cnt_wrap();
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 32'(i), 32'd1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    exp_cnt += 17;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL wrap_empty got=%b want=0", m_valid); end
    total++; if (done_cnt !== 4'd1) begin bad++; $display("FAIL wrap_done_cnt got=%0d want=1", done_cnt); end
    total++; if (m_sum !== 32'd17) begin bad++; $display("FAIL wrap_last_sum got=%0d want=17", m_sum); end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    exp_cnt = 0;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_soak();
    test_reset_midflight();
    test_cnt_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
